z80_io_responder: RTL and testbench
===================================

// Module: z80_io_responder
// PURPOSE
//   Responder side of the Z80 bus for the 48K machine: decodes CPU I/O cycles, holds the ULA port
//   0xFE output latch (border, MIC, speaker), and returns keyboard/EAR data on port reads.
//   Generates the frame interrupt (INT_n) and answers interrupt-acknowledge cycles with 0xFF.
//   Sits between the cpu wrapper (active-low strobes, a, do/di) and video/audio/keyboard logic.
// PARAMETERS
//   INT_PERIOD  69888  T-states per frame; INT_n repeats with this period
//   INT_LENGTH  32     T-states INT_n is held low per frame (1..INT_PERIOD-1)
// PORTS
//   clock    in   1   system clock
//   reset    in   1   synchronous, active-high reset
//   ce       in   1   T-state enable (one pulse per CPU T-state)
//   iorq     in   1   CPU IORQ_n, active low
//   m1       in   1   CPU M1_n, active low
//   rd       in   1   CPU RD_n, active low
//   wr       in   1   CPU WR_n, active low
//   a        in   16  CPU address bus
//   di       in   8   CPU data out (write data)
//   do       out  8   data to CPU data in
//   do_en    out  1   1 = this block drives the CPU data bus this cycle
//   int_n    out  1   frame interrupt to CPU INT_n, active low
//   kb_row   out  8   keyboard half-row select, active low (= a[15:8] during port reads)
//   keys     in   5   keyboard column return, active low
//   ear      in   1   tape EAR input
//   border   out  3   border colour
//   mic      out  1   MIC output bit
//   speaker  out  1   beeper output bit
// BEHAVIOUR
//   Reset values: do=8'hFF, do_en=0, int_n=1, border=0, mic=0, speaker=0, frame counter=0.
//   Decode: ula_sel = !a[0]. io_wr = !iorq & !wr & m1; io_rd = !iorq & !rd & m1; inta = !iorq & !m1.
//   Strobes sampled every clock (not gated by ce); CPU strobes move on cep/cen edges.
//   Write: prev-state register of io_wr; on inactive->active transition with ula_sel, one clock
//     later border<=di[2:0], mic<=di[3], speaker<=di[4]. Exactly one latch per I/O write cycle;
//     writes with a[0]=1 are ignored. di is sampled at the detected edge.
//   Read: while io_rd & ula_sel: do={1'b1, ear, 1'b1, keys}, do_en=1; registered, 1 clock latency.
//     kb_row=a[15:8] combinationally. Other port reads: do_en=0, do=8'hFF.
//   INTA: while inta: do=8'hFF, do_en=1 (IM2 vector FF). inta never triggers read/write decode.
//   Interrupt: on each ce: int_n <= !(cnt < INT_LENGTH); cnt <= (cnt==INT_PERIOD-1) ? 0 : cnt+1.
//     First ce after reset drives int_n low; low for exactly INT_LENGTH ce pulses; period
//     exactly INT_PERIOD ce pulses. Counter width $clog2(INT_PERIOD). Without ce, all hold.
//   INT_n is not cleared by acknowledge; it is purely time-based.
//   Simultaneous events: I/O activity and interrupt timing are independent; reset wins over all.
//   Reset mid-cycle: prev-state register resets to "active" (1), so a write cycle in progress
//     when reset deasserts produces no latch; next full cycle latches normally.
//   Read and write strobes simultaneously low (illegal): write latch proceeds, do_en=1, data
//     still follows read rule.
// STRUCTURE
//   Shared package zx_pkg: INT_PERIOD_48K=69888, INT_LENGTH_48K=32, ULA port decode bit (A0),
//   INTA vector 8'hFF, border/port-FE bit positions.
//   One sub-module: zx_int_gen (frame counter + int_n register, params INT_PERIOD/INT_LENGTH).
//   Remainder (decode, edge detect, port latch, read mux) is flat in this module.
// TESTING
//   Reset, then count ce: int_n low on ce 1..32, high on ce 33, low again at ce 69889.
//   OUT (0xFE),0x15 (iorq/wr low 3 T-states) -> border=5, mic=0, speaker=1, single latch edge.
//   OUT (0xFF),0x07 -> border/mic/speaker unchanged; do_en stays 0.
//   IN a=0xFDFE, keys=5'b11110, ear=0 -> kb_row=8'hFD, do=8'hBE, do_en=1 one clock after rd low.
//   INTA (m1=0, iorq=0) -> do=8'hFF, do_en=1; no port latch; int timing unaffected.
//   Assert reset during OUT 0xFE cycle, release before wr rises -> border stays 0, no latch.

Source files
------------

// File: rtl/zx_pkg.sv
// Shared constants and types for the 48K machine's bus-side logic.
package zx_pkg;
   localparam int INT_PERIOD_48K = 69888;
   localparam int INT_LENGTH_48K = 32;
   localparam int ULA_SEL_BIT    = 0;
   localparam logic [7:0] INTA_VECTOR = 8'hFF;
   localparam int FE_BORDER_LSB  = 0;
   localparam int FE_MIC_BIT     = 3;
   localparam int FE_SPK_BIT     = 4;

   typedef struct packed {
      logic [2:0] border;
      logic       mic;
      logic       speaker;
   } fe_latch_t;

   // Port 0xFE read layout: bits 7 and 5 float high on the real machine.
   function automatic logic [7:0] ula_read_data(input logic ear, input logic [4:0] keys);
      return {1'b1, ear, 1'b1, keys};
   endfunction
endpackage

// File: rtl/zx_int_gen.sv
// Frame interrupt generator: free-running T-state counter with INT_n low at frame start.
module zx_int_gen #(
   parameter int INT_PERIOD = 69888,
   parameter int INT_LENGTH = 32
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_ce,
   output logic o_int_n
);
   localparam int CW = $clog2(INT_PERIOD);

   logic [CW-1:0] r_cnt;
   logic          r_int_n;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_cnt   <= '0;
         r_int_n <= 1'b1;
      end else if (i_ce) begin
         r_int_n <= !(r_cnt < CW'(INT_LENGTH));
         r_cnt   <= (r_cnt == CW'(INT_PERIOD - 1)) ? '0 : r_cnt + CW'(1);
      end
   end

   assign o_int_n = r_int_n;
endmodule

// File: rtl/z80_io_responder.sv
// Z80 I/O responder: port 0xFE latch and keyboard read, INTA vector, frame interrupt.
module z80_io_responder
   import zx_pkg::*;
#(
   parameter int INT_PERIOD = INT_PERIOD_48K,
   parameter int INT_LENGTH = INT_LENGTH_48K
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_ce,
   input  logic        i_iorq,
   input  logic        i_m1,
   input  logic        i_rd,
   input  logic        i_wr,
   input  logic [15:0] i_a,
   input  logic [7:0]  i_di,
   output logic [7:0]  o_do,
   output logic        o_do_en,
   output logic        o_int_n,
   output logic [7:0]  o_kb_row,
   input  logic [4:0]  i_keys,
   input  logic        i_ear,
   output logic [2:0]  o_border,
   output logic        o_mic,
   output logic        o_speaker
);
   logic       w_ula_sel, w_io_wr, w_io_rd, w_inta, w_wr_edge;
   logic       w_unused;
   logic       r_wr_prev, r_wr_pend;
   logic [4:0] r_wdata;
   fe_latch_t  r_fe;
   logic [7:0] r_do;
   logic       r_do_en;

   assign w_ula_sel = ~i_a[ULA_SEL_BIT];
   assign w_io_wr   = ~i_iorq & ~i_wr & i_m1;
   assign w_io_rd   = ~i_iorq & ~i_rd & i_m1;
   assign w_inta    = ~i_iorq & ~i_m1;
   assign w_wr_edge = w_io_wr & ~r_wr_prev & w_ula_sel;
   assign w_unused  = ^{i_a[7:1], i_di[7:5]};

   // r_wr_prev resets to "active" so a write already in flight at reset release is ignored.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wr_prev <= 1'b1;
         r_wr_pend <= 1'b0;
         r_wdata   <= '0;
         r_fe      <= '0;
         r_do      <= 8'hFF;
         r_do_en   <= 1'b0;
      end else begin
         r_wr_prev <= w_io_wr;
         r_wr_pend <= w_wr_edge;
         if (w_wr_edge)
            r_wdata <= i_di[4:0];
         if (r_wr_pend) begin
            r_fe.border  <= r_wdata[FE_BORDER_LSB +: 3];
            r_fe.mic     <= r_wdata[FE_MIC_BIT];
            r_fe.speaker <= r_wdata[FE_SPK_BIT];
         end
         if (w_inta) begin
            r_do    <= INTA_VECTOR;
            r_do_en <= 1'b1;
         end else if (w_io_rd && w_ula_sel) begin
            r_do    <= ula_read_data(i_ear, i_keys);
            r_do_en <= 1'b1;
         end else begin
            r_do    <= 8'hFF;
            r_do_en <= 1'b0;
         end
      end
   end

   zx_int_gen #(
      .INT_PERIOD (INT_PERIOD),
      .INT_LENGTH (INT_LENGTH)
   ) u_int_gen (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_ce    (i_ce),
      .o_int_n (o_int_n)
   );

   assign o_do      = r_do;
   assign o_do_en   = r_do_en;
   assign o_kb_row  = i_a[15:8];
   assign o_border  = r_fe.border;
   assign o_mic     = r_fe.mic;
   assign o_speaker = r_fe.speaker;
endmodule

// File: tb/tb_z80_io_responder.sv
// Randomized bench for z80_io_responder against a counting/port-state reference model.
module tb_z80_io_responder;
   localparam int P = 69888;
   localparam int L = 32;

   logic        clk = 1'b0;
   logic        reset, ce, iorq, m1, rd, wr, ear;
   logic [15:0] a;
   logic [7:0]  di;
   logic [4:0]  keys;
   logic [7:0]  dout, kb_row;
   logic        do_en, int_n, mic, speaker;
   logic [2:0]  border;

   int checks = 0;
   int failures = 0;
   int ce_mode = 1;   // 0 random, 1 every clock, 2 stopped
   int n_ce = 0;
   logic [2:0] m_border = 3'd0;
   logic       m_mic = 1'b0, m_spk = 1'b0;

   z80_io_responder dut (
      .i_clock(clk), .i_reset(reset), .i_ce(ce), .i_iorq(iorq), .i_m1(m1),
      .i_rd(rd), .i_wr(wr), .i_a(a), .i_di(di), .o_do(dout), .o_do_en(do_en),
      .o_int_n(int_n), .o_kb_row(kb_row), .i_keys(keys), .i_ear(ear),
      .o_border(border), .o_mic(mic), .o_speaker(speaker)
   );

   always #5 clk = ~clk;

   // Reference: count ce pulses since reset; INT_n is low for the first L of every P.
   always @(posedge clk) begin
      if (reset) n_ce <= 0;
      else if (ce) n_ce <= n_ce + 1;
   end

   function automatic logic exp_int(input int n);
      if (n == 0) return 1'b1;
      return !(((n - 1) % P) < L);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      case (ce_mode)
         0: ce = 1'($urandom_range(0, 1));
         1: ce = 1'b1;
         default: ce = 1'b0;
      endcase
   endtask

   task automatic idle_bus();
      iorq = 1'b1; m1 = 1'b1; rd = 1'b1; wr = 1'b1;
   endtask

   task automatic model_write(input logic [15:0] addr, input logic [7:0] d);
      if (!addr[0]) begin
         m_border = d[2:0]; m_mic = d[3]; m_spk = d[4];
      end
   endtask

   // di changes to d_late after the falling strobe edge; only d may be latched.
   task automatic bus_write(input logic [15:0] addr, input logic [7:0] d,
                            input logic [7:0] d_late, output logic saw_en);
      saw_en = 1'b0;
      a = addr; di = d;
      tick();
      iorq = 1'b0; wr = 1'b0;
      tick(); saw_en |= do_en;
      di = d_late;
      tick(); saw_en |= do_en;
      tick(); saw_en |= do_en;
      iorq = 1'b1; wr = 1'b1;
      tick(); saw_en |= do_en;
      tick(); saw_en |= do_en;
   endtask

   task automatic test_reset();
      ce_mode = 1; idle_bus();
      a = 16'h0000; di = 8'h00; keys = 5'h1F; ear = 1'b0;
      reset = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (dout !== 8'hFF || do_en !== 1'b0 || int_n !== 1'b1 ||
          {border, mic, speaker} !== 5'b0) begin
         failures++;
         $display("FAIL reset: do=%h do_en=%b int_n=%b border=%0d mic=%b spk=%b, want FF 0 1 0 0 0",
                  dout, do_en, int_n, border, mic, speaker);
      end
      reset = 1'b0;
      m_border = 3'd0; m_mic = 1'b0; m_spk = 1'b0;
   endtask

   task automatic test_int_period();
      logic held;
      ce_mode = 1;
      for (int k = 1; k <= P + L; k++) begin
         tick();
         if (k == 1 || k == 2 || k == L || k == L + 1 || k == L + 2 || k == 1000 ||
             k == P || k == P + 1 || k == P + L) begin
            checks++;
            if (int_n !== exp_int(n_ce)) begin
               failures++;
               $display("FAIL int_timing ce=%0d: int_n=%b want %b", n_ce, int_n, exp_int(n_ce));
            end
         end
      end
      // Next ce would raise INT_n; with ce stopped it must stay low.
      ce_mode = 2; ce = 1'b0;
      held = int_n;
      repeat (5) tick();
      checks++;
      if (int_n !== 1'b0 || held !== 1'b0) begin
         failures++;
         $display("FAIL int_hold: int_n=%b (before %b) want 0", int_n, held);
      end
      ce_mode = 1; ce = 1'b1;
      tick();
      checks++;
      if (int_n !== exp_int(n_ce) || int_n !== 1'b1) begin
         failures++;
         $display("FAIL int_rise ce=%0d: int_n=%b want 1", n_ce, int_n);
      end
   endtask

   task automatic test_out_fe();
      logic en;
      ce_mode = 0;
      bus_write(16'h00FE, 8'h15, 8'h0A, en);
      model_write(16'h00FE, 8'h15);
      checks++;
      if ({border, mic, speaker} !== 5'b101_0_1 || en !== 1'b0) begin
         failures++;
         $display("FAIL out_fe: border=%0d mic=%b spk=%b do_en_seen=%b want 5 0 1 0",
                  border, mic, speaker, en);
      end
   endtask

   task automatic test_out_ff();
      logic en;
      bus_write(16'h00FF, 8'h07, 8'h07, en);
      checks++;
      if ({border, mic, speaker} !== {m_border, m_mic, m_spk} || en !== 1'b0) begin
         failures++;
         $display("FAIL out_ff: border=%0d mic=%b spk=%b do_en_seen=%b want %0d %b %b 0",
                  border, mic, speaker, en, m_border, m_mic, m_spk);
      end
   endtask

   task automatic test_in();
      logic [7:0] exp_do;
      logic       exp_en;
      a = 16'hFDFE; keys = 5'b11110; ear = 1'b0;
      tick();
      iorq = 1'b0; rd = 1'b0;
      checks++;
      if (kb_row !== 8'hFD || do_en !== 1'b0) begin
         failures++;
         $display("FAIL in_latency: kb_row=%h do_en=%b want FD 0", kb_row, do_en);
      end
      tick();
      checks++;
      if (dout !== 8'hBE || do_en !== 1'b1) begin
         failures++;
         $display("FAIL in_fe: do=%h do_en=%b want BE 1", dout, do_en);
      end
      idle_bus();
      tick();
      for (int i = 0; i < 12; i++) begin
         a = 16'($urandom); keys = 5'($urandom); ear = 1'($urandom);
         exp_en = !a[0];
         exp_do = a[0] ? 8'hFF : {1'b1, ear, 1'b1, keys};
         iorq = 1'b0; rd = 1'b0;
         tick();
         checks++;
         if (dout !== exp_do || do_en !== exp_en || kb_row !== a[15:8]) begin
            failures++;
            $display("FAIL in_rand a=%h: do=%h do_en=%b kb_row=%h want %h %b %h",
                     a, dout, do_en, kb_row, exp_do, exp_en, a[15:8]);
         end
         idle_bus();
         tick();
         checks++;
         if (do_en !== 1'b0 || dout !== 8'hFF) begin
            failures++;
            $display("FAIL in_release: do=%h do_en=%b want FF 0", dout, do_en);
         end
      end
   endtask

   task automatic test_inta();
      a = 16'h00FE; di = 8'h1F; keys = 5'b00000; ear = 1'b0;
      m1 = 1'b0; iorq = 1'b0; rd = 1'b0; wr = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (dout !== 8'hFF || do_en !== 1'b1) begin
         failures++;
         $display("FAIL inta: do=%h do_en=%b want FF 1", dout, do_en);
      end
      idle_bus();
      tick(); tick(); tick();
      checks++;
      if ({border, mic, speaker} !== {m_border, m_mic, m_spk} || int_n !== exp_int(n_ce)) begin
         failures++;
         $display("FAIL inta_side: border=%0d mic=%b spk=%b int_n=%b want %0d %b %b %b",
                  border, mic, speaker, int_n, m_border, m_mic, m_spk, exp_int(n_ce));
      end
   endtask

   task automatic test_reset_mid_write();
      logic en;
      a = 16'h00FE; di = 8'h1F;
      tick();
      iorq = 1'b0; wr = 1'b0;
      tick();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      m_border = 3'd0; m_mic = 1'b0; m_spk = 1'b0;
      tick(); tick(); tick();
      idle_bus();
      tick(); tick();
      checks++;
      if ({border, mic, speaker} !== 5'b0) begin
         failures++;
         $display("FAIL reset_mid_write: border=%0d mic=%b spk=%b want 0 0 0", border, mic, speaker);
      end
      bus_write(16'h12FE, 8'h1A, 8'h05, en);
      model_write(16'h12FE, 8'h1A);
      checks++;
      if ({border, mic, speaker} !== 5'b010_1_1) begin
         failures++;
         $display("FAIL after_reset_write: border=%0d mic=%b spk=%b want 2 1 1", border, mic, speaker);
      end
   endtask

   task automatic test_rd_wr_together();
      logic [4:0] k;
      k = 5'($urandom);
      a = 16'h7FFE; di = 8'h0B; keys = k; ear = 1'b1;
      tick();
      iorq = 1'b0; rd = 1'b0; wr = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (dout !== {3'b111, k} || do_en !== 1'b1) begin
         failures++;
         $display("FAIL rd_wr_data: do=%h do_en=%b want %h 1", dout, do_en, {3'b111, k});
      end
      idle_bus();
      tick(); tick();
      model_write(16'h7FFE, 8'h0B);
      checks++;
      if ({border, mic, speaker} !== 5'b011_1_0) begin
         failures++;
         $display("FAIL rd_wr_latch: border=%0d mic=%b spk=%b want 3 1 0", border, mic, speaker);
      end
   endtask

   task automatic test_back_to_back();
      logic en;
      logic [15:0] ad;
      logic [7:0]  d;
      for (int i = 0; i < 12; i++) begin
         ad = 16'($urandom); d = 8'($urandom);
         bus_write(ad, d, ~d, en);
         model_write(ad, d);
         checks++;
         if ({border, mic, speaker} !== {m_border, m_mic, m_spk} || en !== 1'b0) begin
            failures++;
            $display("FAIL b2b_write a=%h d=%h: border=%0d mic=%b spk=%b en=%b want %0d %b %b 0",
                     ad, d, border, mic, speaker, en, m_border, m_mic, m_spk);
         end
      end
      checks++;
      if (int_n !== exp_int(n_ce)) begin
         failures++;
         $display("FAIL int_after_io ce=%0d: int_n=%b want %b", n_ce, int_n, exp_int(n_ce));
      end
   endtask

   initial begin
      reset = 1'b1; ce = 1'b1;
      test_reset();
      test_int_period();
      test_out_fe();
      test_out_ff();
      test_in();
      test_inta();
      test_reset_mid_write();
      test_rd_wr_together();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
